// File: rtl/exec_lsu_pkg.sv
// Shared types for the RV32E execute / load-store stage.
package exec_lsu_pkg;

  localparam int unsigned DataW   = 32;
  localparam int unsigned RegIdxW = 4;

  typedef enum logic [5:0] {
    InstrNop, InstrLui, InstrAuipc, InstrJal, InstrJalr,
    InstrBeq, InstrBne, InstrBlt, InstrBge, InstrBltu, InstrBgeu,
    InstrLb, InstrLh, InstrLw, InstrLbu, InstrLhu,
    InstrSb, InstrSh, InstrSw,
    InstrAddi, InstrSlti, InstrSltiu, InstrXori, InstrOri, InstrAndi,
    InstrSlli, InstrSrli, InstrSrai,
    InstrAdd, InstrSub, InstrSll, InstrSlt, InstrSltu, InstrXor,
    InstrSrl, InstrSra, InstrOr, InstrAnd
  } instr_e;

  typedef struct packed {
    instr_e               instr;
    logic [DataW-1:0]     pc;
    logic [DataW-1:0]     imm;
    logic [RegIdxW-1:0]   rd;
    logic [DataW-1:0]     op1;
    logic [DataW-1:0]     op2;
  } decoded_t;

  typedef enum logic [1:0] {StIdle, StMemReq, StWb} exec_state_t;

  typedef enum logic [1:0] {
    TrapLoadMisalign  = 2'd0,
    TrapStoreMisalign = 2'd1,
    TrapBusTimeout    = 2'd2
  } trap_cause_t;

  typedef enum logic [1:0] {MemByte, MemHalf, MemWord} mem_size_t;

  typedef struct packed {
    logic      is_mem;
    logic      is_store;
    mem_size_t size;
    logic      is_unsigned;
  } mem_op_t;

  // Classify an instruction as a memory access and give its size/sign.
  function automatic mem_op_t mem_decode(instr_e i);
    mem_op_t m;
    m = '{is_mem: 1'b1, is_store: 1'b0, size: MemWord, is_unsigned: 1'b0};
    case (i)
      InstrLb:  m.size = MemByte;
      InstrLh:  m.size = MemHalf;
      InstrLw:  m.size = MemWord;
      InstrLbu: begin m.size = MemByte; m.is_unsigned = 1'b1; end
      InstrLhu: begin m.size = MemHalf; m.is_unsigned = 1'b1; end
      InstrSb:  begin m.size = MemByte; m.is_store = 1'b1; end
      InstrSh:  begin m.size = MemHalf; m.is_store = 1'b1; end
      InstrSw:  begin m.size = MemWord; m.is_store = 1'b1; end
      default:  m.is_mem = 1'b0;
    endcase
    return m;
  endfunction

  // True for instructions that write rd directly from the ALU result.
  function automatic logic writes_rd(instr_e i);
    return !(i inside {InstrNop, InstrBeq, InstrBne, InstrBlt, InstrBge, InstrBltu, InstrBgeu,
                       InstrLb, InstrLh, InstrLw, InstrLbu, InstrLhu,
                       InstrSb, InstrSh, InstrSw});
  endfunction

endpackage

// File: rtl/exec_lsu_unit_alu.sv
// Combinational RV32E ALU: arithmetic/logic result, branch decision and target.
module exec_lsu_unit_alu
  import exec_lsu_pkg::*;
(
  input  instr_e           instr_i,
  input  logic [DataW-1:0] pc_i,
  input  logic [DataW-1:0] imm_i,
  input  logic [DataW-1:0] op1_i,
  input  logic [DataW-1:0] op2_i,
  output logic [DataW-1:0] result_o,
  output logic             taken_o,
  output logic [DataW-1:0] target_o
);

  logic [4:0] shamt_r;
  logic [4:0] shamt_i;

  assign shamt_r = op2_i[4:0];
  assign shamt_i = imm_i[4:0];

  // Decode the instruction into its result, redirect decision and target.
  always_comb begin
    result_o = '0;
    taken_o  = 1'b0;
    target_o = pc_i + imm_i;
    case (instr_i)
      InstrLui:   result_o = imm_i;
      InstrAuipc: result_o = pc_i + imm_i;
      InstrJal: begin
        result_o = pc_i + DataW'(4);
        taken_o  = 1'b1;
      end
      InstrJalr: begin
        result_o = pc_i + DataW'(4);
        taken_o  = 1'b1;
        target_o = (op1_i + imm_i) & ~DataW'(1);
      end
      InstrBeq:   taken_o = (op1_i == op2_i);
      InstrBne:   taken_o = (op1_i != op2_i);
      InstrBlt:   taken_o = ($signed(op1_i) < $signed(op2_i));
      InstrBge:   taken_o = ($signed(op1_i) >= $signed(op2_i));
      InstrBltu:  taken_o = (op1_i < op2_i);
      InstrBgeu:  taken_o = (op1_i >= op2_i);
      InstrAddi:  result_o = op1_i + imm_i;
      InstrSlti:  result_o = {{(DataW-1){1'b0}}, $signed(op1_i) < $signed(imm_i)};
      InstrSltiu: result_o = {{(DataW-1){1'b0}}, op1_i < imm_i};
      InstrXori:  result_o = op1_i ^ imm_i;
      InstrOri:   result_o = op1_i | imm_i;
      InstrAndi:  result_o = op1_i & imm_i;
      InstrSlli:  result_o = op1_i << shamt_i;
      InstrSrli:  result_o = op1_i >> shamt_i;
      InstrSrai:  result_o = DataW'($signed(op1_i) >>> shamt_i);
      InstrAdd:   result_o = op1_i + op2_i;
      InstrSub:   result_o = op1_i - op2_i;
      InstrSll:   result_o = op1_i << shamt_r;
      InstrSlt:   result_o = {{(DataW-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
      InstrSltu:  result_o = {{(DataW-1){1'b0}}, op1_i < op2_i};
      InstrXor:   result_o = op1_i ^ op2_i;
      InstrSrl:   result_o = op1_i >> shamt_r;
      InstrSra:   result_o = DataW'($signed(op1_i) >>> shamt_r);
      InstrOr:    result_o = op1_i | op2_i;
      InstrAnd:   result_o = op1_i & op2_i;
      default:    ;
    endcase
  end

endmodule

// File: rtl/exec_lsu_unit.sv
// RV32E execute stage: single-cycle ALU/branch ops plus a multi-cycle load/store bus FSM.
module exec_lsu_unit
  import exec_lsu_pkg::*;
#(
  parameter int unsigned XLEN        = DataW,
  parameter int unsigned REG_IDX_W   = RegIdxW,
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  decoded_t             in_data,
  output logic                 wr_en,
  output logic [REG_IDX_W-1:0] wr_addr,
  output logic [XLEN-1:0]      wr_data,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [XLEN-1:0]      bus_addr,
  output logic [XLEN-1:0]      bus_wdata,
  output logic [XLEN/8-1:0]    bus_strb,
  input  logic                 bus_ack,
  input  logic [XLEN-1:0]      bus_rdata,
  output logic                 trap_valid,
  output logic [1:0]           trap_cause
);

  localparam int unsigned StrbW = XLEN / 8;
  localparam int unsigned WaitW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;

  exec_state_t          state_q;
  logic                 wr_en_q;
  logic [REG_IDX_W-1:0] wr_addr_q;
  logic [XLEN-1:0]      wr_data_q;
  logic                 redirect_valid_q;
  logic [XLEN-1:0]      redirect_pc_q;
  logic                 bus_req_q;
  logic                 bus_we_q;
  logic [XLEN-1:0]      bus_addr_q;
  logic [XLEN-1:0]      bus_wdata_q;
  logic [StrbW-1:0]     bus_strb_q;
  logic                 trap_valid_q;
  trap_cause_t          trap_cause_q;
  logic [WaitW-1:0]     wait_q;
  logic [1:0]           ld_off_q;
  mem_size_t            ld_size_q;
  logic                 ld_unsigned_q;
  logic [REG_IDX_W-1:0] rd_q;

  logic [XLEN-1:0]  alu_result;
  logic             alu_taken;
  logic [XLEN-1:0]  alu_target;
  mem_op_t          mem_op;
  logic [XLEN-1:0]  ea;
  logic             misaligned;
  logic [XLEN-1:0]  st_wdata;
  logic [StrbW-1:0] st_strb;
  logic [XLEN-1:0]  ld_shifted;
  logic [XLEN-1:0]  ld_value;
  logic             timeout_hit;

  exec_lsu_unit_alu u_alu (
    .instr_i  (in_data.instr),
    .pc_i     (in_data.pc),
    .imm_i    (in_data.imm),
    .op1_i    (in_data.op1),
    .op2_i    (in_data.op2),
    .result_o (alu_result),
    .taken_o  (alu_taken),
    .target_o (alu_target)
  );

  assign mem_op      = mem_decode(in_data.instr);
  assign ea          = in_data.op1 + in_data.imm;
  assign misaligned  = ((mem_op.size == MemHalf) && ea[0]) ||
                       ((mem_op.size == MemWord) && (ea[1:0] != 2'b00));
  // An ack on the timeout edge wins, so this is only consulted when bus_ack is low.
  assign timeout_hit = (BUS_TIMEOUT != 0) && ((32'(wait_q) + 32'd1) == BUS_TIMEOUT);

  // Replicate store data across lanes and build the byte enables from ea[1:0].
  always_comb begin
    st_wdata = in_data.op2;
    st_strb  = '1;
    unique case (mem_op.size)
      MemByte: begin
        st_wdata = {(XLEN/8){in_data.op2[7:0]}};
        st_strb  = StrbW'(4'b0001) << ea[1:0];
      end
      MemHalf: begin
        st_wdata = {(XLEN/16){in_data.op2[15:0]}};
        st_strb  = ea[1] ? StrbW'(4'b1100) : StrbW'(4'b0011);
      end
      default: ;
    endcase
  end

  // Pick the addressed lane of the read data and sign/zero-extend it.
  always_comb begin
    ld_shifted = bus_rdata >> {ld_off_q, 3'b000};
    ld_value   = bus_rdata;
    unique case (ld_size_q)
      MemByte: ld_value = {{(XLEN-8){~ld_unsigned_q & ld_shifted[7]}}, ld_shifted[7:0]};
      MemHalf: ld_value = {{(XLEN-16){~ld_unsigned_q & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ;
    endcase
  end

  // Main FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= StIdle;
      wr_en_q          <= 1'b0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      bus_req_q        <= 1'b0;
      bus_we_q         <= 1'b0;
      bus_addr_q       <= '0;
      bus_wdata_q      <= '0;
      bus_strb_q       <= '0;
      trap_valid_q     <= 1'b0;
      trap_cause_q     <= TrapLoadMisalign;
      wait_q           <= '0;
      ld_off_q         <= 2'b00;
      ld_size_q        <= MemByte;
      ld_unsigned_q    <= 1'b0;
      rd_q             <= '0;
    end else begin
      wr_en_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      trap_valid_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (mem_op.is_mem) begin
              if (misaligned) begin
                trap_valid_q <= 1'b1;
                trap_cause_q <= mem_op.is_store ? TrapStoreMisalign : TrapLoadMisalign;
              end else begin
                bus_req_q     <= 1'b1;
                bus_we_q      <= mem_op.is_store;
                bus_addr_q    <= {ea[XLEN-1:2], 2'b00};
                bus_wdata_q   <= st_wdata;
                bus_strb_q    <= st_strb;
                ld_off_q      <= ea[1:0];
                ld_size_q     <= mem_op.size;
                ld_unsigned_q <= mem_op.is_unsigned;
                rd_q          <= in_data.rd;
                wait_q        <= '0;
                state_q       <= StMemReq;
              end
            end else begin
              if (writes_rd(in_data.instr)) begin
                wr_en_q   <= (in_data.rd != '0);
                wr_addr_q <= in_data.rd;
                wr_data_q <= alu_result;
              end
              if (alu_taken) begin
                redirect_valid_q <= 1'b1;
                redirect_pc_q    <= alu_target;
              end
            end
          end
        end
        StMemReq: begin
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            wait_q    <= '0;
            if (bus_we_q) begin
              state_q <= StIdle;
            end else begin
              wr_en_q   <= (rd_q != '0);
              wr_addr_q <= rd_q;
              wr_data_q <= ld_value;
              state_q   <= StWb;
            end
          end else if (timeout_hit) begin
            bus_req_q    <= 1'b0;
            wait_q       <= '0;
            trap_valid_q <= 1'b1;
            trap_cause_q <= TrapBusTimeout;
            state_q      <= StIdle;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StWb:    state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready       = (state_q == StIdle);
  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign bus_req        = bus_req_q;
  assign bus_we         = bus_we_q;
  assign bus_addr       = bus_addr_q;
  assign bus_wdata      = bus_wdata_q;
  assign bus_strb       = bus_strb_q;
  assign trap_valid     = trap_valid_q;
  assign trap_cause     = trap_cause_q;

endmodule

// File: tb/tb_exec_lsu_unit.sv
// Bench for exec_lsu_unit: transaction-level model plus per-cycle output comparison.
module tb_exec_lsu_unit;
  import exec_lsu_pkg::*;

  localparam int unsigned Timeout = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  decoded_t    in_data;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strb;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        trap_valid;
  logic [1:0]  trap_cause;

  exec_lsu_unit #(
    .XLEN        (32),
    .REG_IDX_W   (4),
    .BUS_TIMEOUT (Timeout)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_strb       (bus_strb),
    .bus_ack        (bus_ack),
    .bus_rdata      (bus_rdata),
    .trap_valid     (trap_valid),
    .trap_cause     (trap_cause)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Expected outputs for the current cycle.
  bit          e_wr_en, e_redir, e_trap, e_bus_req, e_we;
  bit          e_ready = 1'b1;
  logic [3:0]  e_wr_addr, e_strb;
  logic [31:0] e_wr_data, e_redir_pc, e_addr, e_wdata;
  logic [1:0]  e_cause;

  // Model of the outstanding memory transaction.
  bit          m_busy, m_wb;
  int          m_waits;
  instr_e      m_instr;
  logic [31:0] m_ea;
  logic [3:0]  m_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic decoded_t mk(instr_e i, logic [31:0] pc, logic [31:0] imm, logic [3:0] rd,
                                  logic [31:0] a, logic [31:0] b);
    return '{instr: i, pc: pc, imm: imm, rd: rd, op1: a, op2: b};
  endfunction

  // Architectural result of a non-memory instruction.
  function automatic void model_exec(input decoded_t d, output bit wr, output logic [31:0] val,
                                     output bit br, output logic [31:0] tgt);
    logic [31:0] a, b, i, sb;
    int sh;
    a = d.op1; b = d.op2; i = d.imm;
    sb = (d.instr inside {InstrSlli, InstrSrli, InstrSrai}) ? i : b;
    sh = int'(sb[4:0]);
    wr = 1'b1; val = '0; br = 1'b0; tgt = d.pc + i;
    case (d.instr)
      InstrLui:   val = i;
      InstrAuipc: val = d.pc + i;
      InstrJal:   begin val = d.pc + 32'd4; br = 1'b1; end
      InstrJalr:  begin val = d.pc + 32'd4; br = 1'b1; tgt = (a + i) & 32'hFFFF_FFFE; end
      InstrBeq:   begin wr = 1'b0; br = (a == b); end
      InstrBne:   begin wr = 1'b0; br = (a != b); end
      InstrBlt:   begin wr = 1'b0; br = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)); end
      InstrBge:   begin wr = 1'b0; br = !((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)); end
      InstrBltu:  begin wr = 1'b0; br = (a < b); end
      InstrBgeu:  begin wr = 1'b0; br = !(a < b); end
      InstrAddi:  val = a + i;
      InstrSlti:  val = ((a ^ 32'h8000_0000) < (i ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      InstrSltiu: val = (a < i) ? 32'd1 : 32'd0;
      InstrXori:  val = a ^ i;
      InstrOri:   val = a | i;
      InstrAndi:  val = a & i;
      InstrAdd:   val = a + b;
      InstrSub:   val = a + ~b + 32'd1;
      InstrSlt:   val = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      InstrSltu:  val = (a < b) ? 32'd1 : 32'd0;
      InstrXor:   val = a ^ b;
      InstrOr:    val = a | b;
      InstrAnd:   val = a & b;
      InstrSlli, InstrSll: val = a << sh;
      InstrSrli, InstrSrl: val = a >> sh;
      InstrSrai, InstrSra: begin
        val = a >> sh;
        if (a[31] && sh != 0) val = val | ~(32'hFFFF_FFFF >> sh);
      end
      default: wr = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(instr_e i, logic [31:0] ea, logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * int'(ea[1:0]));
    case (i)
      InstrLb:  begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
      InstrLbu: v = v & 32'hFF;
      InstrLh:  begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
      InstrLhu: v = v & 32'hFFFF;
      default:  v = rd;
    endcase
    return v;
  endfunction

  // Advance the model by one rising edge given the inputs that were present at it.
  task automatic model_edge(input bit v, input decoded_t d, input bit ack, input logic [31:0] rdata);
    bit wr, br;
    logic [31:0] val, tgt, ea;
    int off;
    e_wr_en = 1'b0; e_redir = 1'b0; e_trap = 1'b0;
    if (m_busy) begin
      if (ack) begin
        m_busy = 1'b0;
        if (!(m_instr inside {InstrSb, InstrSh, InstrSw})) begin
          m_wb = 1'b1;
          e_wr_en = (m_rd != 0); e_wr_addr = m_rd; e_wr_data = model_load(m_instr, m_ea, rdata);
        end
      end else begin
        m_waits++;
        if (m_waits == Timeout) begin m_busy = 1'b0; e_trap = 1'b1; e_cause = 2'd2; end
      end
    end else if (m_wb) begin
      m_wb = 1'b0;
    end else if (v) begin
      ea = d.op1 + d.imm;
      off = int'(ea[1:0]);
      if (d.instr inside {InstrLb, InstrLh, InstrLw, InstrLbu, InstrLhu, InstrSb, InstrSh, InstrSw})
      begin
        if (((d.instr inside {InstrLh, InstrLhu, InstrSh}) && (off % 2 != 0)) ||
            ((d.instr inside {InstrLw, InstrSw}) && off != 0)) begin
          e_trap = 1'b1;
          e_cause = (d.instr inside {InstrSb, InstrSh, InstrSw}) ? 2'd1 : 2'd0;
        end else begin
          m_busy = 1'b1; m_waits = 0; m_instr = d.instr; m_ea = ea; m_rd = d.rd;
          e_addr = ea - 32'(off);
          e_we = (d.instr inside {InstrSb, InstrSh, InstrSw});
          case (d.instr)
            InstrSb: begin e_wdata = (d.op2 & 32'hFF) * 32'h0101_0101; e_strb = 4'(1 << off); end
            InstrSh: begin
              e_wdata = (d.op2 & 32'hFFFF) * 32'h0001_0001;
              e_strb = (off == 2) ? 4'b1100 : 4'b0011;
            end
            default: begin e_wdata = d.op2; e_strb = 4'b1111; end
          endcase
        end
      end else begin
        model_exec(d, wr, val, br, tgt);
        e_wr_en = wr && (d.rd != 0); e_wr_addr = d.rd; e_wr_data = val;
        e_redir = br; e_redir_pc = tgt;
      end
    end
    e_ready = !m_busy && !m_wb;
    e_bus_req = m_busy;
  endtask

  task automatic step(input bit v, input decoded_t d, input bit ack, input logic [31:0] rdata);
    in_valid = v; in_data = d; bus_ack = ack; bus_rdata = rdata;
    @(posedge clock);
    #1;
    model_edge(v, d, ack, rdata);
  endtask

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("wr_en", 32'(wr_en), 32'(e_wr_en));
      if (e_wr_en) begin
        chk("wr_addr", 32'(wr_addr), 32'(e_wr_addr));
        chk("wr_data", wr_data, e_wr_data);
      end
      chk("redirect_valid", 32'(redirect_valid), 32'(e_redir));
      if (e_redir) chk("redirect_pc", redirect_pc, e_redir_pc);
      chk("trap_valid", 32'(trap_valid), 32'(e_trap));
      if (e_trap) chk("trap_cause", 32'(trap_cause), 32'(e_cause));
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("bus_req", 32'(bus_req), 32'(e_bus_req));
      if (e_bus_req) begin
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_we", 32'(bus_we), 32'(e_we));
        if (e_we) begin
          chk("bus_wdata", bus_wdata, e_wdata);
          chk("bus_strb", 32'(bus_strb), 32'(e_strb));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required to have finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    decoded_t nop_d, d;
    bit v, ack;
    logic [5:0] r;
    nop_d = mk(InstrNop, 0, 0, 0, 0, 0);
    in_data = nop_d;
    m_busy = 0; m_wb = 0; m_waits = 0;

    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    model_edge(1'b0, nop_d, 1'b0, 0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_bus_req", 32'(bus_req), 32'd0);
    chk("reset_trap", 32'(trap_valid), 32'd0);
    chk_en = 1'b1;

    // ALU spot values.
    step(1, mk(InstrAddi, 32'h0, 32'd1, 4'd5, 32'hFFFF_FFFF, 0), 0, 0);
    chk("addi_wr_en", 32'(wr_en), 32'd1);
    chk("addi_wr_addr", 32'(wr_addr), 32'd5);
    chk("addi_wr_data", wr_data, 32'd0);
    step(1, mk(InstrSrai, 32'h0, 32'd4, 4'd6, 32'h8000_0000, 0), 0, 0);
    chk("srai_wr_data", wr_data, 32'hF800_0000);
    step(1, mk(InstrSltu, 32'h0, 32'd0, 4'd7, 32'd1, 32'hFFFF_FFFF), 0, 0);
    chk("sltu_wr_data", wr_data, 32'd1);

    // Branches and JALR.
    step(1, mk(InstrBlt, 32'h100, 32'h20, 4'd1, 32'hFFFF_FFFF, 32'd1), 0, 0);
    chk("blt_redirect", 32'(redirect_valid), 32'd1);
    chk("blt_target", redirect_pc, 32'h120);
    chk("blt_no_write", 32'(wr_en), 32'd0);
    step(1, mk(InstrBltu, 32'h100, 32'h20, 4'd1, 32'hFFFF_FFFF, 32'd1), 0, 0);
    chk("bltu_no_redirect", 32'(redirect_valid), 32'd0);
    step(1, mk(InstrJalr, 32'h400, 32'h0, 4'd1, 32'h203, 0), 0, 0);
    chk("jalr_target", redirect_pc, 32'h202);
    chk("jalr_link", wr_data, 32'h404);

    // Stray ack while idle must be ignored.
    step(0, nop_d, 1, 32'hDEAD_BEEF);

    // LB / LBU at 0x1003 with three wait cycles.
    step(1, mk(InstrLb, 32'h0, 32'd3, 4'd9, 32'h1000, 0), 0, 0);
    chk("lb_bus_addr", bus_addr, 32'h1000);
    repeat (3) step(0, nop_d, 0, 0);
    step(0, nop_d, 1, 32'h8012_3456);
    chk("lb_wr_en", 32'(wr_en), 32'd1);
    chk("lb_wr_data", wr_data, 32'hFFFF_FF80);
    step(0, nop_d, 0, 0);
    step(1, mk(InstrLbu, 32'h0, 32'd3, 4'd9, 32'h1000, 0), 0, 0);
    step(0, nop_d, 1, 32'h8012_3456);
    chk("lbu_wr_data", wr_data, 32'h0000_0080);
    step(0, nop_d, 0, 0);

    // SH lanes.
    step(1, mk(InstrSh, 32'h0, 32'd2, 4'd0, 32'h2000, 32'h1234_ABCD), 0, 0);
    chk("sh_strb", 32'(bus_strb), 32'hC);
    chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);
    chk("sh_addr", bus_addr, 32'h2000);
    step(0, nop_d, 1, 0);

    // Misaligned LW traps without a bus access.
    step(1, mk(InstrLw, 32'h0, 32'd2, 4'd3, 32'h1000, 0), 0, 0);
    chk("lw_mis_trap", 32'(trap_valid), 32'd1);
    chk("lw_mis_cause", 32'(trap_cause), 32'd0);
    chk("lw_mis_no_req", 32'(bus_req), 32'd0);

    // SW with no ack times out.
    step(1, mk(InstrSw, 32'h0, 32'd0, 4'd0, 32'h3000, 32'h5555_AAAA), 0, 0);
    for (int k = 0; k < Timeout; k++) step(0, nop_d, 0, 0);
    chk("timeout_trap", 32'(trap_valid), 32'd1);
    chk("timeout_cause", 32'(trap_cause), 32'd2);
    chk("timeout_ready", 32'(in_ready), 32'd1);

    // Four back-to-back ALU ops, then LUI to x0.
    for (int k = 1; k <= 4; k++) begin
      step(1, mk(InstrAddi, 0, 32'(k), 4'(k), 32'd10, 0), 0, 0);
      chk("b2b_wr_en", 32'(wr_en), 32'd1);
      chk("b2b_wr_data", wr_data, 32'd10 + 32'(k));
      chk("b2b_ready", 32'(in_ready), 32'd1);
    end
    step(1, mk(InstrLui, 0, 32'h1234_5000, 4'd0, 0, 0), 0, 0);
    chk("lui_x0_no_write", 32'(wr_en), 32'd0);

    // Reset during a load after two cycles of bus_req.
    step(1, mk(InstrLw, 32'h0, 32'd0, 4'd4, 32'h4000, 0), 0, 0);
    step(0, nop_d, 0, 0);
    in_valid = 1'b0; bus_ack = 1'b0;
    #2 reset = 1'b0;
    m_busy = 0; m_wb = 0;
    e_wr_en = 0; e_redir = 0; e_trap = 0; e_bus_req = 0; e_ready = 1;
    #1;
    chk("rst_bus_req_drop", 32'(bus_req), 32'd0);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    model_edge(1'b0, nop_d, 1'b0, 0);
    chk("rst_release_ready", 32'(in_ready), 32'd1);
    step(0, nop_d, 1, 32'h1);
    chk("rst_no_write", 32'(wr_en), 32'd0);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      r = 6'($urandom_range(0, 37));
      d.instr = instr_e'(r);
      d.rd  = 4'($urandom);
      d.pc  = $urandom & 32'hFFFF_FFFC;
      d.imm = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 8)) - 32'd4;
      d.op1 = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      d.op2 = ($urandom_range(0, 3) == 0) ? d.op1 : $urandom;
      v   = (!m_busy && !m_wb) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
      ack = ($urandom_range(0, 9) < 4);
      step(v, d, ack, $urandom);
    end
    step(0, nop_d, 1, 0);
    step(0, nop_d, 0, 0);
    step(0, nop_d, 0, 0);

    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
